// File: rtl/alu_nibble_seq_ctrl_pkg.sv
// Shared opcodes and FSM encodings for the nibble-serial ALU sequencer.
package alu_nibble_seq_ctrl_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_NEG = 2'b10;
  localparam logic [1:0] OP_ABS = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/nibble_add.sv
// 4-bit ripple-carry adder slice, time-multiplexed by the sequencer.
module nibble_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] sum,
  output logic       co
);

  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];

endmodule

// File: rtl/alu_nibble_seq_ctrl.sv
// Nibble-serial ADD/SUB/NEG/ABS sequencer around one nibble_add slice.
// Signed overflow flag is built only with SEC_CALC_ALU_OVF_EN defined.
module alu_nibble_seq_ctrl
  import alu_nibble_seq_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 ovf,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t        state;
  logic [W-1:0]  x_sh;
  logic [W-1:0]  y_sh;
  logic [W-1:0]  acc;
  logic [W-1:0]  acc_nx;
  logic          cy;
  logic [IW-1:0] idx;
  logic [3:0]    sum;
  logic          co;
  logic [W-1:0]  x_ld;
  logic [W-1:0]  y_ld;
  logic          c_ld;
  logic          accept;
  logic          last;

  assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;
  assign last   = (state == S_RUN) && (idx == LAST);

  nibble_add u_add (
    .a   (x_sh[3:0]),
    .b   (y_sh[3:0]),
    .ci  (cy),
    .sum (sum),
    .co  (co)
  );

  // ABS sign decision is made here, from A as presented at accept.
  always_comb begin
    x_ld = op_a;
    y_ld = op_b;
    c_ld = 1'b0;
    unique case (cmd_op)
      OP_ADD: ;
      OP_SUB: begin
        y_ld = ~op_b;
        c_ld = 1'b1;
      end
      OP_NEG: begin
        x_ld = '0;
        y_ld = ~op_a;
        c_ld = 1'b1;
      end
      OP_ABS: begin
        if (op_a[W-1]) begin
          x_ld = '0;
          y_ld = ~op_a;
          c_ld = 1'b1;
        end else begin
          y_ld = '0;
        end
      end
    endcase
  end

  always_comb begin
    acc_nx = acc;
    for (int k = 0; k < NIBBLES; k++) begin
      if (idx == IW'(k)) acc_nx[4*k +: 4] = sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      x_sh      <= '0;
      y_sh      <= '0;
      acc       <= '0;
      cy        <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_RUN;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            x_sh      <= x_ld;
            y_sh      <= y_ld;
            cy        <= c_ld;
            idx       <= '0;
          end
        end
        S_RUN: begin
          x_sh <= x_sh >> 4;
          y_sh <= y_sh >> 4;
          cy   <= co;
          acc  <= acc_nx;
          idx  <= idx + 1'b1;
          if (last) begin
            state     <= S_DONE;
            res_valid <= 1'b1;
            result    <= acc_nx;
            carry_out <= co;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state     <= S_IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEC_CALC_ALU_OVF_EN
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic [1:0] op_q;
  logic       a_sgn;
  logic       b_sgn;
  logic       a_min;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf   <= 1'b0;
      op_q  <= OP_ADD;
      a_sgn <= 1'b0;
      b_sgn <= 1'b0;
      a_min <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        a_sgn <= op_a[W-1];
        b_sgn <= op_b[W-1];
        a_min <= (op_a == MIN);
      end
      if (last) begin
        unique case (op_q)
          OP_ADD:
            ovf <= (a_sgn == b_sgn)
                 && (acc_nx[W-1] != a_sgn);
          OP_SUB:
            ovf <= (a_sgn != b_sgn)
                 && (acc_nx[W-1] != a_sgn);
          OP_NEG, OP_ABS:
            ovf <= a_min;
        endcase
      end
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_nibble_seq_ctrl.sv
// Scoreboard bench for alu_nibble_seq_ctrl at NIBBLES=4.
module tb_alu_nibble_seq_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;
`ifdef SEC_CALC_ALU_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         ovf;
  logic         busy;

  exp_t sb[$];
  int   passed;
  int   total;

  alu_nibble_seq_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .carry_out (carry_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [W-1:0] r,
    input logic c,
    input logic v
  );
    exp_t e;
    e.res = r;
    e.c   = c;
    e.v   = v;
    return e;
  endfunction

  // Reference arithmetic on W+1 bits; NEG is 2^W - a.
  function automatic exp_t model(
    input logic [1:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W:0]   s;
    logic [W-1:0] mn;
    logic         v;
    mn = '0;
    mn[W-1] = 1'b1;
    s = '0;
    v = 1'b0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        v = (a[W-1] == b[W-1])
          && (s[W-1] != a[W-1]);
      end
      2'b01: begin
        s = {1'b0, a} + {1'b0, ~b} + 1;
        v = (a[W-1] != b[W-1])
          && (s[W-1] != a[W-1]);
      end
      2'b10: begin
        s = {1'b1, {W{1'b0}}} - {1'b0, a};
        v = (a == mn);
      end
      default: begin
        if (a[W-1])
          s = {1'b1, {W{1'b0}}} - {1'b0, a};
        else
          s = {1'b0, a};
        v = (a == mn);
      end
    endcase
    return mk(s[W-1:0], s[W], v & OVF_EN);
  endfunction

  task automatic send(
    input logic [1:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input exp_t e
  );
    bit acc;
    acc = 1'b0;
    cmd_op = op;
    op_a = a;
    op_b = b;
    cmd_valid = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      total++;
      $display("FAIL send_timeout got no accept want accept");
    end
  endtask

  task automatic recv(input string name);
    exp_t e;
    bit got;
    got = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      if (res_valid) got = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!got || sb.size() == 0) begin
      $display("FAIL %s_timeout got no result want result", name);
    end else begin
      e = sb.pop_front();
      total += 2;
      if (result !== e.res)
        $display("FAIL %s_result got %h want %h", name, result, e.res);
      else passed++;
      if (carry_out !== e.c)
        $display("FAIL %s_carry got %b want %b", name, carry_out, e.c);
      else passed++;
      if (ovf !== e.v)
        $display("FAIL %s_ovf got %b want %b", name, ovf, e.v);
      else passed++;
    end
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string name);
    total += 6;
    if (cmd_ready !== 1'b1)
      $display("FAIL %s_cmd_ready got %b want 1", name, cmd_ready);
    else passed++;
    if (res_valid !== 1'b0)
      $display("FAIL %s_res_valid got %b want 0", name, res_valid);
    else passed++;
    if (result !== '0)
      $display("FAIL %s_result got %h want 0", name, result);
    else passed++;
    if (carry_out !== 1'b0)
      $display("FAIL %s_carry got %b want 0", name, carry_out);
    else passed++;
    if (ovf !== 1'b0)
      $display("FAIL %s_ovf got %b want 0", name, ovf);
    else passed++;
    if (busy !== 1'b0)
      $display("FAIL %s_busy got %b want 0", name, busy);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    op_a = '0;
    op_b = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    int edges;
    send(2'b00, 16'h1234, 16'h0FCC,
         mk(16'h2200, 1'b0, 1'b0));
    edges = 1;
    for (int i = 0; i < 20 && !res_valid; i++) begin
      @(negedge clk);
      edges++;
    end
    total++;
    if (edges != N + 1)
      $display("FAIL add_latency got %0d want %0d", edges, N + 1);
    else passed++;
    recv("add");
  endtask

  task automatic test_sub();
    send(2'b01, 16'h0005, 16'h0007,
         mk(16'hFFFE, 1'b0, 1'b0));
    recv("sub_neg_res");
    send(2'b01, 16'h7FFF, 16'hFFFF,
         mk(16'h8000, 1'b0, OVF_EN));
    recv("sub_ovf");
  endtask

  task automatic test_abs_neg();
    send(2'b11, 16'hFFF6, 16'h1111,
         mk(16'h000A, 1'b0, 1'b0));
    recv("abs_neg_in");
    send(2'b11, 16'h0042, 16'hFFFF,
         mk(16'h0042, 1'b0, 1'b0));
    recv("abs_pos_in");
    send(2'b11, 16'h8000, 16'h0000,
         mk(16'h8000, 1'b0, OVF_EN));
    recv("abs_min");
    send(2'b10, 16'h0000, 16'hABCD,
         mk(16'h0000, 1'b1, 1'b0));
    recv("neg_zero");
    send(2'b10, 16'h8000, 16'h0000,
         mk(16'h8000, 1'b0, OVF_EN));
    recv("neg_min");
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit got;
    e = mk(16'h2200, 1'b0, 1'b0);
    res_ready = 1'b0;
    send(2'b00, 16'h1234, 16'h0FCC, e);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (res_valid) got = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!got) $display("FAIL bp_timeout got no result want result");
    else passed++;
    for (int i = 0; i < 10; i++) begin
      total += 3;
      if (res_valid !== 1'b1)
        $display("FAIL bp_valid got %b want 1", res_valid);
      else passed++;
      if (result !== e.res)
        $display("FAIL bp_stable got %h want %h", result, e.res);
      else passed++;
      if (cmd_ready !== 1'b0)
        $display("FAIL bp_cmd_ready got %b want 0", cmd_ready);
      else passed++;
      @(negedge clk);
    end
    void'(sb.pop_front());
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    total += 3;
    if (res_valid !== 1'b0)
      $display("FAIL bp_release_valid got %b want 0", res_valid);
    else passed++;
    if (cmd_ready !== 1'b1)
      $display("FAIL bp_release_ready got %b want 1", cmd_ready);
    else passed++;
    if (busy !== 1'b0)
      $display("FAIL bp_release_busy got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_busy_reject();
    exp_t e;
    int got;
    bit drop;
    got = 0;
    send(2'b00, 16'h00FF, 16'h0001,
         mk(16'h0100, 1'b0, 1'b0));
    cmd_op = 2'b01;
    op_a = 16'h0100;
    op_b = 16'h0001;
    cmd_valid = 1'b1;
    sb.push_back(mk(16'h00FF, 1'b1, 1'b0));
    res_ready = 1'b1;
    for (int i = 0; i < 100 && got < 2; i++) begin
      drop = 1'b0;
      if (busy) begin
        total++;
        if (cmd_ready !== 1'b0)
          $display("FAIL busy_ready got %b want 0", cmd_ready);
        else passed++;
      end
      if (res_valid && sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if ({result, carry_out} !== {e.res, e.c})
          $display("FAIL busy_order got %h/%b want %h/%b",
                   result, carry_out, e.res, e.c);
        else passed++;
        got++;
      end
      if (cmd_valid && cmd_ready) begin
        drop = 1'b1;
        total++;
        if (got != 1)
          $display("FAIL busy_accept_point got %0d want 1", got);
        else passed++;
      end
      @(negedge clk);
      if (drop) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    total++;
    if (got != 2)
      $display("FAIL busy_count got %0d want 2", got);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    send(2'b00, 16'hFFFF, 16'h0001,
         mk(16'h0000, 1'b1, 1'b0));
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("midrun");
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (res_valid !== 1'b0)
      $display("FAIL midrun_no_result got %b want 0", res_valid);
    else passed++;
    send(2'b00, 16'h1234, 16'h0FCC,
         mk(16'h2200, 1'b0, 1'b0));
    recv("midrun_fresh");
  endtask

  task automatic test_back_to_back();
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      a = W'($urandom);
      b = W'($urandom);
      if (i == 0) begin
        op = 2'b00;
        a = 16'h7000;
        b = 16'h1000;
      end
      res_ready = 1'b1;
      send(op, a, b, model(op, a, b));
      recv("b2b");
    end
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_add();
    test_sub();
    test_abs_neg();
    test_backpressure();
    test_busy_reject();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
